id_ex_stage: RTL and testbench

//  ID/EX pipeline register feeding the 64-bit ALU; decodes the 4-bit alu_operation code.

---
 rtl/id_ex_stage_pkg.sv | 37 +++
 rtl/id_ex_stage_alu_control.sv | 46 ++++
 rtl/id_ex_stage.sv | 105 ++++++++++
 tb/tb_id_ex_stage.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared ALU definitions for the ID/EX stage: operation codes, alu_op classes,
// funct3 values and the bit positions inside the 5-bit control bundle.
package id_ex_stage_pkg;

    typedef enum logic [3:0] {
        ALU_AND     = 4'b0000,
        ALU_OR      = 4'b0001,
        ALU_ADD     = 4'b0010,
        ALU_SUB     = 4'b0110,
        ALU_ILLEGAL = 4'b1111
    } alu_code_e;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_RTYPE = 2'b10,
        ALUOP_ITYPE = 2'b11
    } alu_op_e;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    // ctrl bundle layout: {reg_write, mem_read, mem_write, branch, mem_to_reg}
    localparam int CTRL_W          = 5;
    localparam int CTRL_MEM_TO_REG = 0;
    localparam int CTRL_BRANCH     = 1;
    localparam int CTRL_MEM_WRITE  = 2;
    localparam int CTRL_MEM_READ   = 3;
    localparam int CTRL_REG_WRITE  = 4;

    // Control bits that must never fire for an instruction the ALU cannot execute.
    function automatic logic is_state_changing_bit(input int idx);
        return (idx == CTRL_REG_WRITE) || (idx == CTRL_MEM_WRITE);
    endfunction

endpackage

// File: rtl/id_ex_stage_alu_control.sv
// Combinational ALU control decode: {alu_op, funct3, funct7_5} -> operation code
// plus an illegal flag for funct3 values the ALU does not implement.
module alu_control
    import id_ex_stage_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output logic [3:0] alu_operation,
    output logic       illegal
);

    always_comb begin
        alu_operation = ALU_ADD;
        illegal       = 1'b0;
        case (alu_op)
            ALUOP_ADD: alu_operation = ALU_ADD;
            ALUOP_SUB: alu_operation = ALU_SUB;
            ALUOP_RTYPE: begin
                case (funct3)
                    F3_ADD_SUB: alu_operation = funct7_5 ? ALU_SUB : ALU_ADD;
                    F3_AND:     alu_operation = ALU_AND;
                    F3_OR:      alu_operation = ALU_OR;
                    default: begin
                        alu_operation = ALU_ILLEGAL;
                        illegal       = 1'b1;
                    end
                endcase
            end
            ALUOP_ITYPE: begin
                // Bit 30 of an I-type word is immediate data, so it never selects SUB.
                case (funct3)
                    F3_ADD_SUB: alu_operation = ALU_ADD;
                    F3_AND:     alu_operation = ALU_AND;
                    F3_OR:      alu_operation = ALU_OR;
                    default: begin
                        alu_operation = ALU_ILLEGAL;
                        illegal       = 1'b1;
                    end
                endcase
            end
            default: alu_operation = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: valid/ready handshake from ID, operand-2 select,
// flush, downstream back-pressure and a saturating bubble counter.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    output logic             id_ready,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [XLEN-1:0]  id_rs1_data,
    input  logic [XLEN-1:0]  id_rs2_data,
    input  logic [XLEN-1:0]  id_imm,
    input  logic [4:0]       id_rd,
    input  logic [1:0]       id_alu_op,
    input  logic             id_alu_src,
    input  logic [2:0]       id_funct3,
    input  logic             id_funct7_5,
    input  logic [4:0]       id_ctrl,
    input  logic             flush,
    input  logic             ex_ready,
    output logic             ex_valid,
    output logic [3:0]       ex_alu_operation,
    output logic [XLEN-1:0]  ex_input_data1,
    output logic [XLEN-1:0]  ex_input_data2,
    output logic [XLEN-1:0]  ex_store_data,
    output logic [XLEN-1:0]  ex_pc,
    output logic [4:0]       ex_rd,
    output logic [4:0]       ex_ctrl,
    output logic             ex_illegal,
    output logic [CNT_W-1:0] bubble_count
);

    logic [3:0]        alu_operation_next;
    logic              illegal_next;
    logic [CTRL_W-1:0] ctrl_next;
    logic [XLEN-1:0]   data2_next;
    logic              accept;

    alu_control u_alu_control (
        .alu_op        (id_alu_op),
        .funct3        (id_funct3),
        .funct7_5      (id_funct7_5),
        .alu_operation (alu_operation_next),
        .illegal       (illegal_next)
    );

    assign id_ready   = !ex_valid || ex_ready;
    assign accept     = id_valid && id_ready;
    assign data2_next = id_alu_src ? id_imm : id_rs2_data;

    // An illegal instruction still flows down the pipe but cannot write state.
    generate
        for (genvar gi = 0; gi < CTRL_W; gi++) begin : g_ctrl_mask
            if (is_state_changing_bit(gi)) begin : g_kill
                assign ctrl_next[gi] = id_ctrl[gi] & ~illegal_next;
            end else begin : g_pass
                assign ctrl_next[gi] = id_ctrl[gi];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid         <= 1'b0;
            ex_alu_operation <= '0;
            ex_input_data1   <= '0;
            ex_input_data2   <= '0;
            ex_store_data    <= '0;
            ex_pc            <= '0;
            ex_rd            <= '0;
            ex_ctrl          <= '0;
            ex_illegal       <= 1'b0;
        end else if (flush) begin
            // Data fields are left stale; valid and ctrl are what matter downstream.
            ex_valid   <= 1'b0;
            ex_ctrl    <= '0;
            ex_illegal <= 1'b0;
        end else if (accept) begin
            ex_valid         <= 1'b1;
            ex_alu_operation <= alu_operation_next;
            ex_input_data1   <= id_rs1_data;
            ex_input_data2   <= data2_next;
            ex_store_data    <= id_rs2_data;
            ex_pc            <= id_pc;
            ex_rd            <= id_rd;
            ex_ctrl          <= ctrl_next;
            ex_illegal       <= illegal_next;
        end else if (ex_ready) begin
            ex_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bubble_count <= '0;
        end else if (!ex_valid && !(&bubble_count)) begin
            bubble_count <= bubble_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: hand-computed expectations, one line per transaction.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic        id_ready;
    logic [63:0] id_pc;
    logic [63:0] id_rs1_data;
    logic [63:0] id_rs2_data;
    logic [63:0] id_imm;
    logic [4:0]  id_rd;
    logic [1:0]  id_alu_op;
    logic        id_alu_src;
    logic [2:0]  id_funct3;
    logic        id_funct7_5;
    logic [4:0]  id_ctrl;
    logic        flush;
    logic        ex_ready;
    logic        ex_valid;
    logic [3:0]  ex_alu_operation;
    logic [63:0] ex_input_data1;
    logic [63:0] ex_input_data2;
    logic [63:0] ex_store_data;
    logic [63:0] ex_pc;
    logic [4:0]  ex_rd;
    logic [4:0]  ex_ctrl;
    logic        ex_illegal;
    logic [31:0] bubble_count;

    int checks   = 0;
    int failures = 0;
    bit exp_valid = 1'b0;
    int exp_bubble = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(64), .CNT_W(32)) dut (
        .clk              (clk),
        .reset            (reset),
        .id_valid         (id_valid),
        .id_ready         (id_ready),
        .id_pc            (id_pc),
        .id_rs1_data      (id_rs1_data),
        .id_rs2_data      (id_rs2_data),
        .id_imm           (id_imm),
        .id_rd            (id_rd),
        .id_alu_op        (id_alu_op),
        .id_alu_src       (id_alu_src),
        .id_funct3        (id_funct3),
        .id_funct7_5      (id_funct7_5),
        .id_ctrl          (id_ctrl),
        .flush            (flush),
        .ex_ready         (ex_ready),
        .ex_valid         (ex_valid),
        .ex_alu_operation (ex_alu_operation),
        .ex_input_data1   (ex_input_data1),
        .ex_input_data2   (ex_input_data2),
        .ex_store_data    (ex_store_data),
        .ex_pc            (ex_pc),
        .ex_rd            (ex_rd),
        .ex_ctrl          (ex_ctrl),
        .ex_illegal       (ex_illegal),
        .bubble_count     (bubble_count)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; the bubble model counts edges where ex_valid was expected low.
    task automatic tick(input bit next_valid);
        @(posedge clk);
        if (reset) exp_bubble = 0;
        else if (!exp_valid) exp_bubble++;
        exp_valid = next_valid;
        #1;
    endtask

    task automatic drive(input bit v, input logic [1:0] op, input logic [2:0] f3, input bit f7,
                         input bit src, input logic [63:0] rs1, input logic [63:0] rs2,
                         input logic [63:0] imm, input logic [4:0] rd, input logic [4:0] ctrl);
        id_valid    = v;
        id_alu_op   = op;
        id_funct3   = f3;
        id_funct7_5 = f7;
        id_alu_src  = src;
        id_rs1_data = rs1;
        id_rs2_data = rs2;
        id_imm      = imm;
        id_rd       = rd;
        id_ctrl     = ctrl;
        id_pc       = 64'h1000 + {59'd0, rd};
        #1;
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        ex_ready = 1'b1;
        drive(1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 64'd0, 64'd0, 64'd0, 5'd0, 5'd0);

        // reset
        tick(1'b0);
        tick(1'b0);
        check("rst_valid", ex_valid, 0);
        check("rst_code", ex_alu_operation, 4'b0000);
        check("rst_bubble", bubble_count, 0);
        check("rst_ctrl", ex_ctrl, 0);
        check("rst_illegal", ex_illegal, 0);
        $display("txn reset: ex_valid=%0d bubble=%0d", ex_valid, bubble_count);
        reset = 1'b0;

        // R-type sub
        drive(1'b1, 2'b10, 3'b000, 1'b1, 1'b0, 64'd5, 64'd5, 64'd0, 5'd3, 5'b10000);
        check("sub_id_ready", id_ready, 1);
        tick(1'b1);
        check("sub_valid", ex_valid, 1);
        check("sub_code", ex_alu_operation, 4'b0110);
        check("sub_data1", ex_input_data1, 64'd5);
        check("sub_data2", ex_input_data2, 64'd5);
        check("sub_rd", ex_rd, 5'd3);
        check("sub_pc", ex_pc, 64'h1003);
        check("sub_ctrl", ex_ctrl, 5'b10000);
        check("sub_bubble", bubble_count, 1);
        $display("txn rtype_sub: code=%b d1=%0d d2=%0d", ex_alu_operation, ex_input_data1, ex_input_data2);

        // I-type addi with f7_5=1 (must stay ADD), negative immediate
        drive(1'b1, 2'b11, 3'b000, 1'b1, 1'b1, 64'd3, 64'd9, 64'hFFFF_FFFF_FFFF_FFFC, 5'd4, 5'b10000);
        tick(1'b1);
        check("addi_code", ex_alu_operation, 4'b0010);
        check("addi_data1", ex_input_data1, 64'd3);
        check("addi_data2", ex_input_data2, 64'hFFFF_FFFF_FFFF_FFFC);
        check("addi_store", ex_store_data, 64'd9);
        $display("txn itype_addi: code=%b d2=%h", ex_alu_operation, ex_input_data2);

        // back-pressure: new R-type AND waits three cycles
        ex_ready = 1'b0;
        drive(1'b1, 2'b10, 3'b111, 1'b0, 1'b0, 64'hAA, 64'h0F, 64'd77, 5'd7, 5'b10000);
        check("bp_id_ready", id_ready, 0);
        for (int i = 0; i < 3; i++) begin
            tick(1'b1);
            check("bp_valid", ex_valid, 1);
            check("bp_code", ex_alu_operation, 4'b0010);
            check("bp_data2", ex_input_data2, 64'hFFFF_FFFF_FFFF_FFFC);
            check("bp_rd", ex_rd, 5'd4);
            check("bp_id_ready_hold", id_ready, 0);
        end
        check("bp_bubble", bubble_count, 1);
        $display("txn backpressure: held code=%b rd=%0d", ex_alu_operation, ex_rd);
        ex_ready = 1'b1;
        #1;
        check("bp_release_ready", id_ready, 1);
        tick(1'b1);
        check("and_code", ex_alu_operation, 4'b0000);
        check("and_data1", ex_input_data1, 64'hAA);
        check("and_data2", ex_input_data2, 64'h0F);
        check("and_rd", ex_rd, 5'd7);
        $display("txn rtype_and: code=%b d1=%h d2=%h", ex_alu_operation, ex_input_data1, ex_input_data2);

        // I-type ori
        drive(1'b1, 2'b11, 3'b110, 1'b0, 1'b1, 64'h1, 64'h2, 64'h10, 5'd8, 5'b10000);
        tick(1'b1);
        check("ori_code", ex_alu_operation, 4'b0001);
        check("ori_data2", ex_input_data2, 64'h10);
        $display("txn itype_ori: code=%b d2=%h", ex_alu_operation, ex_input_data2);

        // alu_op 00 ignores funct3, alu_op 01 always SUB
        drive(1'b1, 2'b00, 3'b101, 1'b1, 1'b1, 64'h20, 64'h30, 64'h8, 5'd9, 5'b01001);
        tick(1'b1);
        check("ld_code", ex_alu_operation, 4'b0010);
        check("ld_illegal", ex_illegal, 0);
        check("ld_ctrl", ex_ctrl, 5'b01001);
        $display("txn aluop00: code=%b illegal=%0d", ex_alu_operation, ex_illegal);
        drive(1'b1, 2'b01, 3'b001, 1'b0, 1'b0, 64'h20, 64'h30, 64'h8, 5'd10, 5'b00010);
        tick(1'b1);
        check("br_code", ex_alu_operation, 4'b0110);
        check("br_data2", ex_input_data2, 64'h30);
        $display("txn aluop01: code=%b", ex_alu_operation);

        // flush drops the incoming instruction
        drive(1'b1, 2'b10, 3'b000, 1'b0, 1'b0, 64'h1, 64'h1, 64'h0, 5'd11, 5'b11111);
        flush = 1'b1;
        tick(1'b0);
        check("flush_valid", ex_valid, 0);
        check("flush_ctrl", ex_ctrl, 0);
        check("flush_bubble", bubble_count, exp_bubble);
        flush = 1'b0;
        drive(1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 64'd0, 64'd0, 64'd0, 5'd0, 5'd0);
        tick(1'b0);
        check("flush_bubble_inc", bubble_count, exp_bubble);
        check("flush_bubble_abs", bubble_count, 2);
        $display("txn flush: ex_valid=%0d ctrl=%b bubble=%0d", ex_valid, ex_ctrl, bubble_count);

        // illegal R-type funct3=001: reg_write and mem_write suppressed
        drive(1'b1, 2'b10, 3'b001, 1'b0, 1'b0, 64'h4, 64'h5, 64'h0, 5'd12, 5'b11101);
        tick(1'b1);
        check("ill_code", ex_alu_operation, 4'b1111);
        check("ill_flag", ex_illegal, 1);
        check("ill_ctrl", ex_ctrl, 5'b01001);
        $display("txn illegal: code=%b illegal=%0d ctrl=%b", ex_alu_operation, ex_illegal, ex_ctrl);

        // bubble when ID has nothing
        drive(1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 64'd0, 64'd0, 64'd0, 5'd0, 5'd0);
        tick(1'b0);
        check("bub_valid", ex_valid, 0);
        tick(1'b0);
        check("bub_count", bubble_count, exp_bubble);
        $display("txn bubble: ex_valid=%0d bubble=%0d", ex_valid, bubble_count);

        // reset beats flush and handshake
        drive(1'b1, 2'b00, 3'b000, 1'b0, 1'b0, 64'h5, 64'h6, 64'h0, 5'd13, 5'b10000);
        reset = 1'b1;
        flush = 1'b1;
        tick(1'b0);
        check("rst2_valid", ex_valid, 0);
        check("rst2_bubble", bubble_count, 0);
        check("rst2_data1", ex_input_data1, 0);
        $display("txn reset_priority: ex_valid=%0d bubble=%0d", ex_valid, bubble_count);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
